// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encoding, register-index width,
// default memory timeout and the bit positions of the hazard priority decode.
package pipe_ctrl_pkg;

  localparam int REG_W           = 5;
  localparam int DEF_MEM_TIMEOUT = 255;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2,
    ILLEGAL  = 2'd3
  } pipe_state_e;

  // One-hot priority decode: memory wait > branch flush > load-use stall
  localparam int SEL_WAIT     = 0;
  localparam int SEL_BRANCH   = 1;
  localparam int SEL_LOAD_USE = 2;
  localparam int SEL_W        = 3;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: purely combinational load-use compare and one-hot priority
// decode of the three pipeline events seen from the RUN state.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             load_use,
  output logic [SEL_W-1:0] sel
);

  logic wait_req;

  // x0 is hardwired zero, so a load targeting it can never create a hazard
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  assign wait_req = mem_req && !mem_ready;

  always_comb begin
    sel = '0;
    if (wait_req)             sel[SEL_WAIT]     = 1'b1;
    else if (ex_branch_taken) sel[SEL_BRANCH]   = 1'b1;
    else if (load_use)        sel[SEL_LOAD_USE] = 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/freeze controller for a 5-stage pipeline with a
// memory-wait FSM, deferred redirect and sticky timeout. Optional
// performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write_en,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [1:0]       state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  pipe_state_e      state_q, state_d;
  logic             pend_q, pend_d;
  logic             lu_block_q;
  logic             lu_stall;
  logic             load_use;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_sat;

  hazard_detect u_hazard_detect (
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .load_use        (load_use),
    .sel             (sel)
  );

  assign state = state_q;

  // Outputs are forced to their idle values while reset is low, so the
  // combinational paths cannot leak a freeze during an asynchronous reset.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pc_write_en = 1'b1;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    lu_stall    = 1'b0;
    if (!reset) begin
      state_d = RUN;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (sel[SEL_WAIT]) begin
            pipe_freeze = 1'b1;
            if_id_stall = 1'b1;
            pc_write_en = 1'b0;
            state_d     = MEM_WAIT;
            if (ex_branch_taken) pend_d = 1'b1;
          end else if (sel[SEL_BRANCH]) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (sel[SEL_LOAD_USE] && !lu_block_q) begin
            pc_write_en = 1'b0;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            lu_stall    = 1'b1;
          end
        end
        MEM_WAIT: begin
          // EX is frozen here, so a branch seen now is ignored
          if (!mem_ready) begin
            pipe_freeze = 1'b1;
            if_id_stall = 1'b1;
            pc_write_en = 1'b0;
          end else begin
            state_d = pend_q ? REDIRECT : RUN;
          end
        end
        REDIRECT: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          pend_d      = 1'b0;
          state_d     = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      pend_q     <= 1'b0;
      lu_block_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      // One bubble per hazard: stay blocked while the same hazard persists
      lu_block_q <= lu_stall | (lu_block_q & load_use);
    end
  end

  assign wait_cnt_sat = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q  <= '0;
      mem_timeout <= 1'b0;
    end else if (state_q == MEM_WAIT && !mem_ready) begin
      wait_cnt_q <= wait_cnt_sat;
      if (wait_cnt_sat == CNT_MAX) mem_timeout <= 1'b1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pipe_freeze || lu_stall) stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush)             flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule
